bp_uart_bridge: RTL

- Bridges an asynchronous 8N1 UART line to the 8-bit bytepipe valid/ready interface used by the register-memory block.
- RX path: deserialises bytes from the host UART and presents them on o_bp_* to the register-memory input.
- TX path: accepts response bytes on i_bp_* from the register-memory output and serialises them to the host.
- Sits directly upstream and downstream of the register-memory block, between the board UART pins and the bytepipe fabric.

---
 rtl/bp_uart_bridge_pkg.sv | 14 +
 rtl/bp_uart_bridge_sync_2ff.sv | 28 ++
 rtl/bp_uart_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_uart_bridge_pkg.sv
// Shared constants and UART framing state encodings for the bytepipe UART bridge.
package bp_uart_bridge_pkg;

  localparam int BP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/bp_uart_bridge_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, with selectable reset level
// and clock-gate hold.
module bp_uart_bridge_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else if (i_cg) begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/bp_uart_bridge.sv
// 8N1 UART <-> bytepipe bridge: RX deserialiser with a one-deep holding register,
// TX serialiser with valid/ready acceptance. RX and TX run independently.
module bp_uart_bridge
  import bp_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cg,
  input  logic            i_uart_rx,
  output logic            o_uart_tx,
  output logic [BP_W-1:0] o_bp_data,
  output logic            o_bp_valid,
  input  logic            i_bp_ready,
  input  logic [BP_W-1:0] i_bp_data,
  input  logic            i_bp_valid,
  output logic            o_bp_ready,
  output logic            o_rx_overrun,
  output logic            o_rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  bp_uart_bridge_sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cg  (i_cg),
    .i_d   (i_uart_rx),
    .o_q   (rx_s)
  );

  // ---------------- RX framing ----------------
  uart_state_e     rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [BP_W-1:0]  rx_shift_q, rx_shift_d;
  logic             ferr_q, ferr_d;
  logic             rx_deliver;
  logic             rx_expired;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    ferr_d     = ferr_q;
    rx_deliver = 1'b0;
    rx_expired = (rx_cnt_q == '0);
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_state_d = ST_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (!rx_expired) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else if (rx_s) begin
          rx_state_d = ST_IDLE;
        end else begin
          rx_state_d = ST_DATA;
          rx_cnt_d   = CNT_FULL;
          rx_idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (!rx_expired) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_shift_d = {rx_s, rx_shift_q[BP_W-1:1]};
          rx_cnt_d   = CNT_FULL;
          if (rx_idx_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (!rx_expired) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else if (rx_s) begin
          rx_deliver = 1'b1;
          rx_state_d = ST_IDLE;
        end else begin
          ferr_d     = 1'b1;
          rx_state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Line held low past the stop bit: wait for idle before hunting again.
        if (rx_s) rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= '0;
      ferr_q     <= 1'b0;
    end else if (i_cg) begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      ferr_q     <= ferr_d;
    end
  end

  // ---------------- RX holding register ----------------
  logic [BP_W-1:0] bp_data_q, bp_data_d;
  logic            bp_valid_q, bp_valid_d;
  logic            ovr_q, ovr_d;

  always_comb begin
    bp_data_d  = bp_data_q;
    bp_valid_d = bp_valid_q;
    ovr_d      = ovr_q;
    if (rx_deliver) begin
      // A handshake this cycle frees the slot, so the new byte can load.
      if (!bp_valid_q || i_bp_ready) begin
        bp_data_d  = rx_shift_q;
        bp_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bp_valid_q && i_bp_ready) begin
      bp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bp_data_q  <= '0;
      bp_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (i_cg) begin
      bp_data_q  <= bp_data_d;
      bp_valid_q <= bp_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  // ---------------- TX serialiser ----------------
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [BP_W-1:0]  tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_expired;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_expired = (tx_cnt_q == '0);
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (i_bp_valid && tx_ready_q) begin
          tx_shift_d = i_bp_data;
          tx_state_d = ST_START;
          tx_cnt_d   = CNT_FULL;
          tx_line_d  = 1'b0;
        end
      end
      ST_START: begin
        if (!tx_expired) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_idx_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[BP_W-1:1]};
        end
      end
      ST_DATA: begin
        if (!tx_expired) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_cnt_d = CNT_FULL;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[BP_W-1:1]};
          end
        end
      end
      ST_STOP: begin
        if (!tx_expired) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
    tx_ready_d = (tx_state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else if (i_cg) begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign o_uart_tx      = tx_line_q;
  assign o_bp_ready     = tx_ready_q;
  assign o_bp_data      = bp_data_q;
  assign o_bp_valid     = bp_valid_q;
  assign o_rx_overrun   = ovr_q;
  assign o_rx_frame_err = ferr_q;

endmodule
